// File: rtl/riscv_defines.sv
// riscv_defines: shared load/store encodings, access sizes and LSU state type.
// Revision 1.0
`default_nettype none

package riscv_defines;

  localparam int WORD_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LH   = 3'd2,
    LD_LW   = 3'd3,
    LD_LBU  = 3'd4,
    LD_LHU  = 3'd5
  } load_type_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } store_type_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'd0,
    LSU_REQ         = 2'd1,
    LSU_WAIT_RVALID = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] byte_enable(input access_size_e size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// load_align: picks the addressed lane of a read word and sign/zero-extends it.
// Revision 1.0
`default_nettype none

module load_align
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  load_type_e             load_type_i,
  input  logic [1:0]             byte_off_i,
  input  logic [WORD_WIDTH-1:0]  rdata_i,
  output logic [WORD_WIDTH-1:0]  rdata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (byte_off_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (load_type_i)
      LD_LB:   rdata_o = {{(WORD_WIDTH-8){w_byte[7]}}, w_byte};
      LD_LBU:  rdata_o = {{(WORD_WIDTH-8){1'b0}}, w_byte};
      LD_LH:   rdata_o = {{(WORD_WIDTH-16){w_half[15]}}, w_half};
      LD_LHU:  rdata_o = {{(WORD_WIDTH-16){1'b0}}, w_half};
      LD_LW:   rdata_o = rdata_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine on a req/gnt/rvalid data bus.
// Revision 1.0
`default_nettype none

module load_store_unit
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  misalign_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  output logic [3:0]            data_be_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i
);

  lsu_state_e            r_state;
  lsu_state_e            w_state_nxt;
  logic                  r_we;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;
  load_type_e            r_ltype;
  logic [1:0]            r_off;
  logic                  r_done;
  logic                  r_misalign;
  logic [WORD_WIDTH-1:0] r_rdata;

  logic                  w_is_store;
  logic                  w_is_load;
  access_size_e          w_size;
  logic                  w_misaligned;
  logic                  w_valid_op;
  logic                  w_accept;
  logic                  w_complete;
  logic [WORD_WIDTH-1:0] w_wdata_rep;
  logic [WORD_WIDTH-1:0] w_load_result;

  // Store takes priority when both type fields are nonzero.
  always_comb begin
    w_is_store = (store_type_i != ST_NONE);
    w_is_load  = (load_type_i >= 3'd1) && (load_type_i <= 3'd5);
    w_size     = SZ_WORD;
    if (w_is_store) begin
      case (store_type_i)
        ST_SB:   w_size = SZ_BYTE;
        ST_SH:   w_size = SZ_HALF;
        default: w_size = SZ_WORD;
      endcase
    end else begin
      case (load_type_i)
        LD_LB, LD_LBU: w_size = SZ_BYTE;
        LD_LH, LD_LHU: w_size = SZ_HALF;
        default:       w_size = SZ_WORD;
      endcase
    end
    w_misaligned = ((w_size == SZ_WORD) && (addr_i[1:0] != 2'b00)) ||
                   ((w_size == SZ_HALF) && addr_i[0]);
    w_valid_op   = req_i && (r_state == LSU_IDLE) && (w_is_store || w_is_load);
    w_accept     = w_valid_op && !w_misaligned;
    w_complete   = (r_state == LSU_WAIT_RVALID) && data_rvalid_i;
    case (w_size)
      SZ_BYTE: w_wdata_rep = WORD_WIDTH'({4{wdata_i[7:0]}});
      SZ_HALF: w_wdata_rep = WORD_WIDTH'({2{wdata_i[15:0]}});
      default: w_wdata_rep = wdata_i;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE:        if (w_accept)      w_state_nxt = LSU_REQ;
      LSU_REQ:         if (data_gnt_i)    w_state_nxt = LSU_WAIT_RVALID;
      LSU_WAIT_RVALID: if (data_rvalid_i) w_state_nxt = LSU_IDLE;
      default:                            w_state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_state_nxt;
  end

  load_align #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_load_align (
    .load_type_i (r_ltype),
    .byte_off_i  (r_off),
    .rdata_i     (data_rdata_i),
    .rdata_o     (w_load_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 4'b0000;
      r_ltype    <= LD_NONE;
      r_off      <= 2'b00;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= w_is_store;
        r_addr  <= {addr_i[WORD_WIDTH-1:2], 2'b00};
        r_wdata <= w_is_store ? w_wdata_rep : '0;
        r_be    <= byte_enable(w_size, addr_i[1:0]);
        r_ltype <= w_is_store ? LD_NONE : load_type_e'(load_type_i);
        r_off   <= addr_i[1:0];
      end
      r_done     <= w_complete;
      r_misalign <= w_valid_op && w_misaligned;
      if (w_complete) begin
        r_rdata <= (r_ltype != LD_NONE) ? w_load_result : '0;
      end
    end
  end

  assign busy_o       = (r_state != LSU_IDLE);
  assign data_req_o   = (r_state == LSU_REQ);
  assign done_o       = r_done;
  assign misalign_o   = r_misalign;
  assign rdata_o      = r_rdata;
  assign data_we_o    = r_we;
  assign data_addr_o  = r_addr;
  assign data_wdata_o = r_wdata;
  assign data_be_o    = r_be;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for load_store_unit.
// Revision 1.0
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_rdata_i;
  logic        data_gnt_i;
  logic        data_rvalid_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .load_type_i   (load_type_i),
    .store_type_i  (store_type_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rdata_o       (rdata_o),
    .misalign_o    (misalign_o),
    .data_req_o    (data_req_o),
    .data_we_o     (data_we_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_be_o     (data_be_o),
    .data_rdata_i  (data_rdata_i),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i)
  );

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gw;
    logic        mis;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic        ewe;
    logic [31:0] ewdata;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: actual %h required %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input int idx);
    chk("rst_busy", idx, 32'(busy_o), 32'd0);
    chk("rst_done", idx, 32'(done_o), 32'd0);
    chk("rst_misalign", idx, 32'(misalign_o), 32'd0);
    chk("rst_req", idx, 32'(data_req_o), 32'd0);
    chk("rst_we", idx, 32'(data_we_o), 32'd0);
    chk("rst_be", idx, 32'(data_be_o), 32'd0);
    chk("rst_addr", idx, data_addr_o, 32'd0);
    chk("rst_wdata", idx, data_wdata_o, 32'd0);
    chk("rst_rdata", idx, rdata_o, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int req_cycles;
    @(negedge clk);
    req_i = 1'b1; load_type_i = v.lt; store_type_i = v.st; addr_i = v.addr; wdata_i = v.wdata;
    @(negedge clk);
    if (v.mis) begin
      req_i = 1'b0;
      chk("mis_pulse", idx, 32'(misalign_o), 32'd1);
      chk("mis_busy", idx, 32'(busy_o), 32'd0);
      chk("mis_req", idx, 32'(data_req_o), 32'd0);
      @(negedge clk);
      chk("mis_pulse_end", idx, 32'(misalign_o), 32'd0);
      chk("mis_req2", idx, 32'(data_req_o), 32'd0);
      chk("mis_busy2", idx, 32'(busy_o), 32'd0);
    end else begin
      // A different, valid request held while busy must be ignored.
      load_type_i = 3'd3; store_type_i = 2'd0; addr_i = 32'h0000_0FF0;
      chk("acc_mis", idx, 32'(misalign_o), 32'd0);
      chk("acc_busy", idx, 32'(busy_o), 32'd1);
      chk("bus_addr", idx, data_addr_o, v.eaddr);
      chk("bus_be", idx, 32'(data_be_o), 32'(v.ebe));
      chk("bus_we", idx, 32'(data_we_o), 32'(v.ewe));
      if (v.ewe) chk("bus_wdata", idx, data_wdata_o, v.ewdata);
      req_cycles = data_req_o ? 1 : 0;
      for (int w = 0; w < v.gw; w++) begin
        data_rvalid_i = 1'b1;
        @(negedge clk);
        if (data_req_o) req_cycles++;
      end
      data_rvalid_i = 1'b0;
      chk("held_addr", idx, data_addr_o, v.eaddr);
      data_gnt_i = 1'b1;
      @(negedge clk);
      data_gnt_i = 1'b0; req_i = 1'b0;
      chk("req_cycles", idx, 32'(req_cycles), 32'(v.gw + 1));
      chk("req_drop", idx, 32'(data_req_o), 32'd0);
      chk("wait_busy", idx, 32'(busy_o), 32'd1);
      chk("wait_done", idx, 32'(done_o), 32'd0);
      data_rvalid_i = 1'b1; data_rdata_i = v.rdata;
      @(negedge clk);
      data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      chk("done", idx, 32'(done_o), 32'd1);
      chk("done_busy", idx, 32'(busy_o), 32'd0);
      if (!v.ewe) chk("rdata", idx, rdata_o, v.erdata);
      @(negedge clk);
      chk("done_once", idx, 32'(done_o), 32'd0);
      chk("idle_busy", idx, 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    //          lt    st    addr          wdata         rdata         gw mis eaddr         ebe      ewe   ewdata        erdata
    vecs[0]  = '{3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 32'h0,        2, 0, 32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{3'd1, 2'd0, 32'h203, 32'h0,        32'h80FFFF00, 0, 0, 32'h200, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{3'd4, 2'd0, 32'h203, 32'h0,        32'h80FFFF00, 1, 0, 32'h200, 4'b1000, 1'b0, 32'h0, 32'h00000080};
    vecs[3]  = '{3'd0, 2'd2, 32'h22,  32'h0000ABCD, 32'h0,        0, 0, 32'h20,  4'b1100, 1'b1, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{3'd0, 2'd1, 32'h31,  32'h12345678, 32'h0,        0, 0, 32'h30,  4'b0010, 1'b1, 32'h78787878, 32'h0};
    vecs[5]  = '{3'd2, 2'd0, 32'h42,  32'h0,        32'h80017FFF, 0, 0, 32'h40,  4'b1100, 1'b0, 32'h0, 32'hFFFF8001};
    vecs[6]  = '{3'd5, 2'd0, 32'h40,  32'h0,        32'h8001F00F, 0, 0, 32'h40,  4'b0011, 1'b0, 32'h0, 32'h0000F00F};
    vecs[7]  = '{3'd3, 2'd0, 32'h5C,  32'h0,        32'hCAFEF00D, 3, 0, 32'h5C,  4'b1111, 1'b0, 32'h0, 32'hCAFEF00D};
    vecs[8]  = '{3'd1, 2'd0, 32'h61,  32'h0,        32'h00007F00, 0, 0, 32'h60,  4'b0010, 1'b0, 32'h0, 32'h0000007F};
    vecs[9]  = '{3'd2, 2'd0, 32'h11,  32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{3'd0, 2'd3, 32'h102, 32'h1,        32'h0,        0, 1, 32'h0,   4'b0000, 1'b0, 32'h0, 32'h0};
    vecs[11] = '{3'd3, 2'd0, 32'h7,   32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 1'b0, 32'h0, 32'h0};
    vecs[12] = '{3'd0, 2'd2, 32'h23,  32'h5,        32'h0,        0, 1, 32'h0,   4'b0000, 1'b0, 32'h0, 32'h0};
    vecs[13] = '{3'd3, 2'd1, 32'h13,  32'h000000AB, 32'h0,        0, 0, 32'h10,  4'b1000, 1'b1, 32'hABABABAB, 32'h0};

    rst = 1'b1; req_i = 1'b0; load_type_i = 3'd0; store_type_i = 2'd0;
    addr_i = 32'h0; wdata_i = 32'h0; data_rdata_i = 32'h0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero(0);
    rst = 1'b0;

    // Stray gnt/rvalid while idle.
    @(negedge clk);
    data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    chk("stray_busy", 0, 32'(busy_o), 32'd0);
    chk("stray_done", 0, 32'(done_o), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reserved load type 6 is no operation.
    @(negedge clk);
    req_i = 1'b1; load_type_i = 3'd6; store_type_i = 2'd0; addr_i = 32'h3;
    @(negedge clk);
    req_i = 1'b0;
    chk("lt6_busy", 0, 32'(busy_o), 32'd0);
    chk("lt6_mis", 0, 32'(misalign_o), 32'd0);
    chk("lt6_req", 0, 32'(data_req_o), 32'd0);

    // Back-to-back: SH then LW accepted in the done cycle.
    @(negedge clk);
    req_i = 1'b1; load_type_i = 3'd0; store_type_i = 2'd2; addr_i = 32'h22; wdata_i = 32'h0000ABCD;
    @(negedge clk);
    req_i = 1'b0;
    chk("b2b_wdata", 0, data_wdata_o, 32'hABCDABCD);
    chk("b2b_be", 0, 32'(data_be_o), 32'hC);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    chk("b2b_done1", 0, 32'(done_o), 32'd1);
    req_i = 1'b1; load_type_i = 3'd3; store_type_i = 2'd0; addr_i = 32'h44;
    @(negedge clk);
    req_i = 1'b0;
    chk("b2b_done1_end", 0, 32'(done_o), 32'd0);
    chk("b2b_req", 0, 32'(data_req_o), 32'd1);
    chk("b2b_addr", 0, data_addr_o, 32'h44);
    chk("b2b_be2", 0, 32'(data_be_o), 32'hF);
    chk("b2b_we", 0, 32'(data_we_o), 32'd0);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h13572468;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    chk("b2b_done2", 0, 32'(done_o), 32'd1);
    chk("b2b_rdata", 0, rdata_o, 32'h13572468);

    // Reset while waiting for rvalid, then a stray rvalid.
    @(negedge clk);
    req_i = 1'b1; load_type_i = 3'd3; store_type_i = 2'd0; addr_i = 32'h80;
    @(negedge clk);
    req_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    chk("pre_rst_busy", 0, 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero(1);
    @(negedge clk);
    rst = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    chk("post_rst_done", 0, 32'(done_o), 32'd0);
    chk("post_rst_busy", 0, 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("post_rst_done2", 0, 32'(done_o), 32'd0);
    chk("post_rst_rdata", 0, rdata_o, 32'd0);
    run_vec(vecs[1], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data/address width.
REQ-002 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have req_i  in  1  memory-op request from writeback side, qualified by type fields.
REQ-005 SHALL have load_type_i  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU (6,7 treated as none).
REQ-006 SHALL have store_type_i  in  2  0 none, 1 SB, 2 SH, 3 SW.
REQ-007 SHALL have addr_i  in  WORD_WIDTH  byte address (ALU result); wdata_i  in  WORD_WIDTH  store data, low-aligned.
REQ-008 SHALL have busy_o  out  1  high while a transaction is in flight; upstream stalls.
REQ-009 SHALL have done_o  out  1  one-cycle completion pulse; rdata_o  out  WORD_WIDTH  extended load result, valid with done_o for loads.
REQ-010 SHALL have misalign_o  out  1  one-cycle pulse on rejected misaligned request.
REQ-011 SHALL have data_req_o, data_we_o  out  1; data_addr_o, data_wdata_o  out  WORD_WIDTH; data_be_o  out  4; data_rdata_i  in  WORD_WIDTH; data_gnt_i, data_rvalid_i  in  1 (req/gnt/rvalid bus).

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> WAIT_RVALID -> IDLE; busy_o = (state != IDLE).
REQ-013 IDLE: req_i with nonzero, aligned op SHALL register addr/be/wdata/we/type and enter REQ next edge; store wins if both types nonzero.
REQ-014 Misalignment: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0 -> no bus access, stay IDLE, misalign_o high next cycle only.
REQ-015 REQ: data_req_o=1 and all data_* outputs stable until data_gnt_i sampled high; then WAIT_RVALID; data_req_o low from next cycle.
REQ-016 WAIT_RVALID: on data_rvalid_i, go IDLE; done_o (and rdata_o for loads) registered, high the following cycle for exactly one cycle.
REQ-017 Latency: accept at cycle N, data_req_o at N+1; gnt and rvalid same cycle -> minimum 3 cycles from accept to done_o.
REQ-018 IDLE accepts a new request in the cycle done_o is high; req_i while busy_o SHALL be ignored.
REQ-019 data_addr_o = {addr[WORD_WIDTH-1:2],2'b00}; data_we_o=1 only for stores.
REQ-020 be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111; same rule for loads.
REQ-021 Store data SHALL be lane-replicated: SB {4{b}}, SH {2{h}}, SW unchanged.
REQ-022 Load: select lane by registered addr[1:0], sign-extend LB/LH, zero-extend LBU/LHU, LW passthrough.
REQ-023 data_rvalid_i outside WAIT_RVALID and data_gnt_i outside REQ SHALL be ignored.
REQ-024 No outstanding-transaction overlap: at most one transaction in flight.

Reset
REQ-025 On rst: state IDLE, all outputs 0 (data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, busy_o, done_o, misalign_o, rdata_o).
REQ-026 Reset mid-transaction SHALL abandon it with no done_o; a later stray rvalid is ignored per REQ-023.

Structure
REQ-027 Load/store type encodings and WORD_WIDTH SHALL live in shared package riscv_defines.
REQ-028 Lane-select/extension logic SHALL be one combinational sub-module load_align; FSM and registers in load_store_unit.

Verification
REQ-029 SW addr 0x100 wdata 0xDEADBEEF, gnt after 2 wait cycles, rvalid 1 later -> req held 3 cycles, addr 0x100, be 1111, we 1, done_o once.
REQ-030 LB addr 0x203, rdata_i 0x80FF_FF00 -> be 1000, rdata_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 LH addr 0x11 -> misalign_o pulse one cycle, data_req_o never asserted, busy_o stays 0.
REQ-032 SH addr 0x22 wdata 0x0000ABCD -> data_wdata_o 0xABCDABCD, be 1100; back-to-back LW accepted in done_o cycle.
REQ-033 rst asserted in WAIT_RVALID, then rvalid pulse -> all outputs 0, no done_o, next request works normally.
